// File: rtl/timer_pkg.sv
// Shared definitions for the timer family: state encoding and a counter-width helper.
package timer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int bits_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Divides the clock down to a one-cycle tick per millisecond while enabled.
module ms_prescaler
  import timer_pkg::*;
#(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = bits_for(CLKS_PER_MS);
  localparam logic [PW-1:0] TERM = PW'(CLKS_PER_MS - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable millisecond countdown with pause/resume, warning level and expiry pulse.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int MAX_MS      = 5000,
  parameter int CLKS_PER_MS = 50000,
  parameter int WARN_MS     = 1000,
  localparam int MS_W       = $clog2(MAX_MS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [MS_W-1:0] load_ms,
  input  logic            start,
  input  logic            pause,
  output logic [MS_W-1:0] remaining_ms,
  output logic            running,
  output logic            warning,
  output logic            expired,
  output logic            done,
  output state_t          state_dbg
);

  localparam logic [MS_W-1:0] MAX_V  = MS_W'(MAX_MS);
  localparam logic [MS_W-1:0] WARN_V = (WARN_MS > MAX_MS) ? MS_W'(MAX_MS) : MS_W'(WARN_MS);

  state_t          state_q, state_d;
  logic [MS_W-1:0] rem_q, rem_d;
  logic            expired_q, expired_d;
  logic            pre_en, pre_clr, tick;

  // Control inputs are plain strobes sampled every edge; there is no handshake
  // and load always outranks start/pause.
  assign pre_en = (state_q == ST_RUN) && !load;

  ms_prescaler #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    expired_d = 1'b0;
    pre_clr   = 1'b0;
    if (load) begin
      rem_d   = (load_ms > MAX_V) ? MAX_V : load_ms;
      state_d = ST_IDLE;
      pre_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (rem_q != '0) begin
              state_d = ST_RUN;
              pre_clr = 1'b1;
            end else begin
              state_d   = ST_DONE;
              expired_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          // A tick on the same edge as pause still lands; reaching zero beats pause.
          if (tick && (rem_q != '0)) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == MS_W'(1)) begin
              state_d   = ST_DONE;
              expired_d = 1'b1;
            end else if (pause) begin
              state_d = ST_PAUSE;
            end
          end else if (pause) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          rem_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      expired_q <= expired_d;
    end
  end

  assign remaining_ms = rem_q;
  assign running      = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);
  assign warning      = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && (rem_q <= WARN_V);
  assign expired      = expired_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: vector table, directed corner sequences and random traffic.
module tb_countdown_timer;

  localparam int C    = 4;
  localparam int MAXV = 20;
  localparam int WARN = 3;
  localparam int W    = 5;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] load_ms;
  logic         start;
  logic         pause;
  logic [W-1:0] remaining_ms;
  logic         running;
  logic         warning;
  logic         expired;
  logic         done;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  countdown_timer #(
    .MAX_MS     (MAXV),
    .CLKS_PER_MS(C),
    .WARN_MS    (WARN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_ms     (load_ms),
    .start       (start),
    .pause       (pause),
    .remaining_ms(remaining_ms),
    .running     (running),
    .warning     (warning),
    .expired     (expired),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];

  // Reference: remaining time is the loaded value minus whole ms of counting edges.
  int   m_n;
  int   m_active;
  int   m_mode;
  logic m_exp;

  typedef struct {
    logic         ld;
    logic [W-1:0] ms;
    logic         st;
    logic         pa;
    logic [W-1:0] rem;
    logic         run;
    logic         warn;
    logic         ex;
    logic         dn;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  task automatic model_reset();
    m_n      = 0;
    m_active = 0;
    m_mode   = M_IDLE;
    m_exp    = 1'b0;
  endtask

  task automatic model_step(input logic l, input logic [W-1:0] ms, input logic s, input logic p);
    m_exp = 1'b0;
    if (l) begin
      m_n      = (int'(ms) > MAXV) ? MAXV : int'(ms);
      m_active = 0;
      m_mode   = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (s) begin
            if (m_n == 0) begin
              m_mode = M_DONE;
              m_exp  = 1'b1;
            end else begin
              m_mode   = M_RUN;
              m_active = 0;
            end
          end
        end
        M_RUN: begin
          m_active++;
          if (m_active >= m_n * C) begin
            m_mode = M_DONE;
            m_exp  = 1'b1;
          end else if (p) begin
            m_mode = M_PAUSE;
          end
        end
        M_PAUSE: if (s) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  function automatic logic [8:0] model_outputs();
    int   rem;
    logic run, warn, dn;
    rem = (m_mode == M_DONE) ? 0 : m_n - m_active / C;
    if (rem < 0) rem = 0;
    run  = (m_mode == M_RUN);
    warn = ((m_mode == M_RUN) || (m_mode == M_PAUSE)) && (rem <= WARN);
    dn   = (m_mode == M_DONE);
    return {run, warn, m_exp, dn, rem[W-1:0]};
  endfunction

  // Called #1 after a rising edge; applies inputs across the next edge and scores it.
  task automatic drive_cycle(input logic l, input logic [W-1:0] ms, input logic s, input logic p);
    logic [8:0] got;
    load    = l;
    load_ms = ms;
    start   = s;
    pause   = p;
    model_step(l, ms, s, p);
    exp_q.push_back(model_outputs());
    @(posedge clk);
    #1;
    got = {running, warning, expired, done, remaining_ms};
    check("model", {23'd0, got}, {23'd0, exp_q.pop_front()});
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_exp, pulses, warn_rise, first_dec;

    reset   = 1'b0;
    load    = 1'b0;
    load_ms = '0;
    start   = 1'b0;
    pause   = 1'b0;
    model_reset();

    vecs[0]  = '{1'b1, 5'd25, 1'b0, 1'b0, 5'd20, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd2,  1'b0, 1'b0, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  1'b1, 1'b0, 5'd2,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd2,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd2,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  1'b0, 1'b1, 5'd2,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  1'b0, 1'b1, 5'd2,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  1'b1, 1'b0, 5'd2,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd1,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  1'b1, 1'b0, 5'd1,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd1,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd1,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 5'd0,  1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 5'd3,  1'b0, 1'b0, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 5'd0,  1'b1, 1'b0, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 5'd7,  1'b1, 1'b0, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 5'd0,  1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0};

    // Clock/reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {23'd0, running, warning, expired, done, remaining_ms}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b1;

    // Vector table
    for (int i = 0; i < 21; i++) begin
      drive_cycle(vecs[i].ld, vecs[i].ms, vecs[i].st, vecs[i].pa);
      check($sformatf("vec%0d", i), {23'd0, running, warning, expired, done, remaining_ms},
            {23'd0, vecs[i].run, vecs[i].warn, vecs[i].ex, vecs[i].dn, vecs[i].rem});
    end

    // Basic countdown from 5
    drive_cycle(1'b1, 5'd5, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    first_exp = -1; pulses = 0; warn_rise = -1;
    for (int k = 1; k <= 24; k++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b0);
      if (k < 20) check("basic_rem", {27'd0, remaining_ms}, 32'(5 - k / C));
      if (expired) begin
        pulses++;
        if (first_exp < 0) first_exp = k;
      end
      if (warning && warn_rise < 0) warn_rise = k;
    end
    check("basic_expire_cycle", first_exp, 20);
    check("basic_pulses", pulses, 1);
    check("basic_warn_rise", warn_rise, 8);
    check("basic_done_held", {31'd0, done}, 32'd1);

    // Pause 6 cycles after start, hold 10 cycles, resume
    drive_cycle(1'b1, 5'd5, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    first_exp = -1; first_dec = -1;
    for (int k = 1; k <= 40; k++) begin
      drive_cycle(1'b0, '0, (k == 16), (k == 6));
      if (k >= 6 && k <= 16) check("pause_hold", {27'd0, remaining_ms}, 32'd4);
      if (k > 16 && first_dec < 0 && remaining_ms == 5'd3) first_dec = k;
      if (expired && first_exp < 0) first_exp = k;
    end
    check("resume_first_dec", first_dec, 18);
    check("pause_expire_cycle", first_exp, 30);

    // Reset asserted between edges while running at 3
    drive_cycle(1'b1, 5'd5, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    idle_cycles(9);
    check("pre_reset_rem", {27'd0, remaining_ms}, 32'd3);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", {23'd0, running, warning, expired, done, remaining_ms}, 32'd0);
    check("async_reset_state", {30'd0, state_dbg}, 32'd0);
    model_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    check("zero_start_done", {30'd0, done, expired}, 32'd3);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    check("zero_start_pulse_end", {30'd0, done, expired}, 32'd2);

    // Random traffic against the reference model
    drive_cycle(1'b1, 5'($urandom_range(1, 25)), 1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      drive_cycle(($urandom_range(0, 39) == 0), 5'($urandom_range(0, 25)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
